lmd_align_unit: RTL and testbench



---
 rtl/lmd_align_if.sv | 32 +++
 rtl/lmd_align_unit.sv | 131 +++++++++++++
 tb/tb_lmd_align_unit.sv | 193 +++++++++++++++++++
 3 files changed

// File: rtl/lmd_align_if.sv
// Load-memory-data request/response bundle between control, data memory and the align unit.
// Ports: lmd/size/sext/addr_lo request, mem_rdata/mem_ready memory side,
//        d_out/valid/busy/err_align/err_timeout results back to the datapath and control FSM.
interface lmd_align_if #(
  parameter int DATA_W = 32
);
  localparam int OFF_W = $clog2(DATA_W / 8);

  logic              lmd;
  logic [1:0]        size;
  logic              sext;
  logic [OFF_W-1:0]  addr_lo;
  logic [DATA_W-1:0] mem_rdata;
  logic              mem_ready;
  logic [DATA_W-1:0] d_out;
  logic              valid;
  logic              busy;
  logic              err_align;
  logic              err_timeout;

  // Requester side: control FSM plus data memory.
  modport master (
    output lmd, size, sext, addr_lo, mem_rdata, mem_ready,
    input  d_out, valid, busy, err_align, err_timeout
  );

  // The align unit itself.
  modport slave (
    input  lmd, size, sext, addr_lo, mem_rdata, mem_ready,
    output d_out, valid, busy, err_align, err_timeout
  );
endinterface

// File: rtl/lmd_align_unit.sv
// Load-memory-data register: waits (bounded) for memory, selects the addressed lane, extends it.
// Ports: clk, rst_n (sync, active-low), bus (lmd_align_if.slave) carrying request, memory
//        read data/ready and the held d_out plus valid/busy/err_align/err_timeout flags.
module lmd_align_unit #(
  parameter int DATA_W     = 32,
  parameter int BIG_ENDIAN = 0,
  parameter int MAX_WAIT   = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  lmd_align_if.slave  bus
);
  localparam int OFF_W = $clog2(DATA_W / 8);
  localparam int CW    = $clog2(MAX_WAIT + 1);

  typedef enum logic {S_IDLE, S_WAIT} state_t;

  state_t            state, state_n;
  logic [CW-1:0]     cnt, cnt_n;
  logic [1:0]        r_size, r_size_n;
  logic              r_sext, r_sext_n;
  logic [OFF_W-1:0]  r_off, r_off_n;
  logic [DATA_W-1:0] d_out_q, d_out_n;
  logic              valid_q, valid_n;
  logic              err_align_q, err_align_n;
  logic              err_to_q, err_to_n;

  // Request legality: offset must be a multiple of the access size, and a
  // doubleword only exists on a 64-bit datapath.
  logic [OFF_W-1:0]  off_mask;
  logic              size_ok;
  logic              legal;

  always_comb begin
    off_mask = OFF_W'((4'd1 << bus.size) - 4'd1);
    size_ok  = !((bus.size == 2'b11) && (DATA_W == 32));
    legal    = size_ok && ((bus.addr_lo & off_mask) == '0);
  end

  // Lane select and extension from the latched request.
  // sh_fld = number of bits above the field once it is right-justified.
  // Little-endian shifts right by the byte position; big-endian puts byte 0
  // at the top, so the field sits sh_fld - 8*offset bits above bit 0.
  logic [7:0]        sh_fld, byte_pos, sh_off;
  logic [DATA_W-1:0] shifted, fmask, ext;
  logic              msb;

  always_comb begin
    sh_fld   = 8'(DATA_W) - (8'd8 << r_size);
    byte_pos = 8'({r_off, 3'b000});
    sh_off   = (BIG_ENDIAN != 0) ? (sh_fld - byte_pos) : byte_pos;
    shifted  = bus.mem_rdata >> sh_off;
    fmask    = {DATA_W{1'b1}} >> sh_fld;
    // fmask ^ (fmask >> 1) is a one-hot at the field MSB; for a full-width
    // field ~fmask is zero so sext has no effect.
    msb      = |(shifted & (fmask ^ (fmask >> 1)));
    ext      = (shifted & fmask) | ((r_sext && msb) ? ~fmask : '0);
  end

  always_comb begin
    state_n     = state;
    cnt_n       = cnt;
    r_size_n    = r_size;
    r_sext_n    = r_sext;
    r_off_n     = r_off;
    d_out_n     = d_out_q;
    valid_n     = 1'b0;
    err_align_n = 1'b0;
    err_to_n    = 1'b0;
    case (state)
      S_IDLE: begin
        if (bus.lmd) begin
          if (legal) begin
            r_size_n = bus.size;
            r_sext_n = bus.sext;
            r_off_n  = bus.addr_lo;
            cnt_n    = '0;
            state_n  = S_WAIT;
          end else begin
            err_align_n = 1'b1;
          end
        end
      end
      S_WAIT: begin
        // A ready on the last allowed cycle still wins over the timeout.
        if (bus.mem_ready) begin
          d_out_n = ext;
          valid_n = 1'b1;
          state_n = S_IDLE;
        end else begin
          cnt_n = cnt + 1'b1;
          if (cnt == CW'(MAX_WAIT - 1)) begin
            err_to_n = 1'b1;
            state_n  = S_IDLE;
          end
        end
      end
      default: state_n = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= S_IDLE;
      cnt         <= '0;
      r_size      <= '0;
      r_sext      <= 1'b0;
      r_off       <= '0;
      d_out_q     <= '0;
      valid_q     <= 1'b0;
      err_align_q <= 1'b0;
      err_to_q    <= 1'b0;
    end else begin
      state       <= state_n;
      cnt         <= cnt_n;
      r_size      <= r_size_n;
      r_sext      <= r_sext_n;
      r_off       <= r_off_n;
      d_out_q     <= d_out_n;
      valid_q     <= valid_n;
      err_align_q <= err_align_n;
      err_to_q    <= err_to_n;
    end
  end

  assign bus.d_out       = d_out_q;
  assign bus.valid       = valid_q;
  assign bus.busy        = (state == S_WAIT);
  assign bus.err_align   = err_align_q;
  assign bus.err_timeout = err_to_q;
endmodule

// File: tb/tb_lmd_align_unit.sv
module tb_lmd_align_unit;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_vec = 0;
  int   n_err = 0;

  always #5 clk = ~clk;

  lmd_align_if #(.DATA_W(32)) ifa ();
  lmd_align_if #(.DATA_W(32)) ifb ();
  lmd_align_if #(.DATA_W(64)) ifc ();

  lmd_align_unit #(.DATA_W(32), .BIG_ENDIAN(0), .MAX_WAIT(4)) dut_a (.clk(clk), .rst_n(rst_n), .bus(ifa));
  lmd_align_unit #(.DATA_W(32), .BIG_ENDIAN(1), .MAX_WAIT(4)) dut_b (.clk(clk), .rst_n(rst_n), .bus(ifb));
  lmd_align_unit #(.DATA_W(64), .BIG_ENDIAN(0), .MAX_WAIT(8)) dut_c (.clk(clk), .rst_n(rst_n), .bus(ifc));

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic init_inputs();
    ifa.lmd = 0; ifa.size = 0; ifa.sext = 0; ifa.addr_lo = 0; ifa.mem_rdata = 0; ifa.mem_ready = 0;
    ifb.lmd = 0; ifb.size = 0; ifb.sext = 0; ifb.addr_lo = 0; ifb.mem_rdata = 0; ifb.mem_ready = 0;
    ifc.lmd = 0; ifc.size = 0; ifc.sext = 0; ifc.addr_lo = 0; ifc.mem_rdata = 0; ifc.mem_ready = 0;
  endtask

  task automatic test_reset();
    rst_n = 0;
    tick(); tick();
    n_vec++; if (ifa.d_out !== 32'h0) begin n_err++; $display("FAIL reset_d_out got %h want %h", ifa.d_out, 32'h0); end
    n_vec++; if (ifa.valid !== 1'b0) begin n_err++; $display("FAIL reset_valid got %b want 0", ifa.valid); end
    n_vec++; if (ifa.busy !== 1'b0) begin n_err++; $display("FAIL reset_busy got %b want 0", ifa.busy); end
    n_vec++; if ({ifa.err_align, ifa.err_timeout} !== 2'b00) begin n_err++; $display("FAIL reset_errs got %b want 00", {ifa.err_align, ifa.err_timeout}); end
    n_vec++; if (ifc.d_out !== 64'h0) begin n_err++; $display("FAIL reset_d_out64 got %h want 0", ifc.d_out); end
    rst_n = 1;
    tick();
  endtask

  task automatic test_byte_sext();
    ifa.lmd = 1; ifa.size = 2'b00; ifa.sext = 1; ifa.addr_lo = 2'd3;
    tick();
    ifa.lmd = 0;
    n_vec++; if (ifa.busy !== 1'b1) begin n_err++; $display("FAIL bsext_busy got %b want 1", ifa.busy); end
    n_vec++; if (ifa.valid !== 1'b0) begin n_err++; $display("FAIL bsext_early_valid got %b want 0", ifa.valid); end
    ifa.mem_rdata = 32'h80FF1234; ifa.mem_ready = 1;
    tick();
    ifa.mem_ready = 0;
    n_vec++; if (ifa.valid !== 1'b1) begin n_err++; $display("FAIL bsext_valid got %b want 1", ifa.valid); end
    n_vec++; if (ifa.d_out !== 32'hFFFFFF80) begin n_err++; $display("FAIL bsext_d_out got %h want %h", ifa.d_out, 32'hFFFFFF80); end
    n_vec++; if (ifa.busy !== 1'b0) begin n_err++; $display("FAIL bsext_busy_end got %b want 0", ifa.busy); end
    tick();
    n_vec++; if (ifa.valid !== 1'b0) begin n_err++; $display("FAIL bsext_valid_pulse got %b want 0", ifa.valid); end
  endtask

  task automatic test_back_to_back();
    ifa.lmd = 1; ifa.size = 2'b01; ifa.sext = 0; ifa.addr_lo = 2'd2;
    tick();
    ifa.lmd = 0; ifa.mem_rdata = 32'h80FF1234; ifa.mem_ready = 1;
    tick();
    ifa.mem_ready = 0;
    n_vec++; if (ifa.d_out !== 32'h000080FF) begin n_err++; $display("FAIL half_zext_d_out got %h want %h", ifa.d_out, 32'h000080FF); end
    // Next load issued in the very first IDLE cycle after the valid edge.
    ifa.lmd = 1; ifa.size = 2'b10; ifa.sext = 1; ifa.addr_lo = 2'd0;
    tick();
    ifa.lmd = 0;
    n_vec++; if (ifa.busy !== 1'b1) begin n_err++; $display("FAIL b2b_busy got %b want 1", ifa.busy); end
    ifa.mem_rdata = 32'hDEADBEEF; ifa.mem_ready = 1;
    tick();
    ifa.mem_ready = 0;
    n_vec++; if (ifa.valid !== 1'b1) begin n_err++; $display("FAIL b2b_valid got %b want 1", ifa.valid); end
    n_vec++; if (ifa.d_out !== 32'hDEADBEEF) begin n_err++; $display("FAIL b2b_d_out got %h want %h", ifa.d_out, 32'hDEADBEEF); end
  endtask

  task automatic test_misalign();
    ifa.lmd = 1; ifa.size = 2'b01; ifa.sext = 0; ifa.addr_lo = 2'd1;
    tick();
    ifa.lmd = 0;
    n_vec++; if (ifa.err_align !== 1'b1) begin n_err++; $display("FAIL misalign_err got %b want 1", ifa.err_align); end
    n_vec++; if (ifa.busy !== 1'b0) begin n_err++; $display("FAIL misalign_busy got %b want 0", ifa.busy); end
    n_vec++; if (ifa.d_out !== 32'hDEADBEEF) begin n_err++; $display("FAIL misalign_d_out got %h want %h", ifa.d_out, 32'hDEADBEEF); end
    tick();
    n_vec++; if (ifa.err_align !== 1'b0) begin n_err++; $display("FAIL misalign_pulse got %b want 0", ifa.err_align); end
    // Word at a half-aligned offset.
    ifa.lmd = 1; ifa.size = 2'b10; ifa.addr_lo = 2'd2;
    tick();
    ifa.lmd = 0;
    n_vec++; if (ifa.err_align !== 1'b1) begin n_err++; $display("FAIL misalign_word_err got %b want 1", ifa.err_align); end
    tick();
    // Doubleword is never legal on a 32-bit datapath.
    ifa.lmd = 1; ifa.size = 2'b11; ifa.addr_lo = 2'd0;
    tick();
    ifa.lmd = 0;
    n_vec++; if ({ifa.err_align, ifa.busy} !== 2'b10) begin n_err++; $display("FAIL dword32_err got %b want 10", {ifa.err_align, ifa.busy}); end
    tick();
  endtask

  task automatic test_lmd_in_wait();
    ifa.lmd = 1; ifa.size = 2'b00; ifa.sext = 0; ifa.addr_lo = 2'd0; ifa.mem_ready = 0;
    tick();
    tick();   // lmd still high while in WAIT
    n_vec++; if (ifa.busy !== 1'b1) begin n_err++; $display("FAIL wait_lmd_busy got %b want 1", ifa.busy); end
    ifa.lmd = 0; ifa.mem_rdata = 32'hCAFE00A5; ifa.mem_ready = 1;
    tick();
    ifa.mem_ready = 0;
    n_vec++; if (ifa.d_out !== 32'h000000A5) begin n_err++; $display("FAIL wait_lmd_d_out got %h want %h", ifa.d_out, 32'h000000A5); end
    tick();
    n_vec++; if ({ifa.busy, ifa.valid} !== 2'b00) begin n_err++; $display("FAIL wait_lmd_queued got %b want 00", {ifa.busy, ifa.valid}); end
  endtask

  task automatic test_timeout();
    ifa.lmd = 1; ifa.size = 2'b10; ifa.addr_lo = 2'd0; ifa.mem_ready = 0;
    tick();
    ifa.lmd = 0;
    tick(); tick(); tick();
    n_vec++; if ({ifa.busy, ifa.err_timeout} !== 2'b10) begin n_err++; $display("FAIL timeout_early got %b want 10", {ifa.busy, ifa.err_timeout}); end
    tick();
    n_vec++; if (ifa.err_timeout !== 1'b1) begin n_err++; $display("FAIL timeout_err got %b want 1", ifa.err_timeout); end
    n_vec++; if ({ifa.busy, ifa.valid, ifa.err_align} !== 3'b000) begin n_err++; $display("FAIL timeout_flags got %b want 000", {ifa.busy, ifa.valid, ifa.err_align}); end
    n_vec++; if (ifa.d_out !== 32'h000000A5) begin n_err++; $display("FAIL timeout_d_out got %h want %h", ifa.d_out, 32'h000000A5); end
    tick();
    n_vec++; if (ifa.err_timeout !== 1'b0) begin n_err++; $display("FAIL timeout_pulse got %b want 0", ifa.err_timeout); end
    // Ready arriving on the last allowed WAIT cycle still completes.
    ifa.lmd = 1;
    tick();
    ifa.lmd = 0;
    tick(); tick(); tick();
    ifa.mem_rdata = 32'h11223344; ifa.mem_ready = 1;
    tick();
    ifa.mem_ready = 0;
    n_vec++; if ({ifa.valid, ifa.err_timeout} !== 2'b10) begin n_err++; $display("FAIL late_ready_flags got %b want 10", {ifa.valid, ifa.err_timeout}); end
    n_vec++; if (ifa.d_out !== 32'h11223344) begin n_err++; $display("FAIL late_ready_d_out got %h want %h", ifa.d_out, 32'h11223344); end
  endtask

  task automatic test_big_endian();
    ifb.lmd = 1; ifb.size = 2'b00; ifb.sext = 1; ifb.addr_lo = 2'd0;
    tick();
    ifb.lmd = 0; ifb.mem_rdata = 32'h80FF1234; ifb.mem_ready = 1;
    tick();
    ifb.mem_ready = 0;
    n_vec++; if (ifb.d_out !== 32'hFFFFFF80) begin n_err++; $display("FAIL be_byte_d_out got %h want %h", ifb.d_out, 32'hFFFFFF80); end
    ifb.lmd = 1; ifb.size = 2'b01; ifb.sext = 1; ifb.addr_lo = 2'd2;
    tick();
    ifb.lmd = 0; ifb.mem_ready = 1;
    tick();
    ifb.mem_ready = 0;
    n_vec++; if (ifb.d_out !== 32'h00001234) begin n_err++; $display("FAIL be_half_d_out got %h want %h", ifb.d_out, 32'h00001234); end
  endtask

  task automatic test_dword64();
    ifc.lmd = 1; ifc.size = 2'b11; ifc.sext = 1; ifc.addr_lo = 3'd0;
    tick();
    ifc.lmd = 0; ifc.mem_rdata = 64'h8123456789ABCDEF; ifc.mem_ready = 1;
    tick();
    ifc.mem_ready = 0;
    n_vec++; if (ifc.d_out !== 64'h8123456789ABCDEF) begin n_err++; $display("FAIL dword_d_out got %h want %h", ifc.d_out, 64'h8123456789ABCDEF); end
    ifc.lmd = 1; ifc.size = 2'b10; ifc.sext = 1; ifc.addr_lo = 3'd4;
    tick();
    ifc.lmd = 0; ifc.mem_rdata = 64'h9000000112345678; ifc.mem_ready = 1;
    tick();
    ifc.mem_ready = 0;
    n_vec++; if (ifc.d_out !== 64'hFFFFFFFF90000001) begin n_err++; $display("FAIL word64_sext_d_out got %h want %h", ifc.d_out, 64'hFFFFFFFF90000001); end
  endtask

  task automatic test_reset_mid_wait();
    ifc.lmd = 1; ifc.size = 2'b00; ifc.sext = 0; ifc.addr_lo = 3'd1;
    tick();
    ifc.lmd = 0;
    n_vec++; if (ifc.busy !== 1'b1) begin n_err++; $display("FAIL rstwait_busy got %b want 1", ifc.busy); end
    rst_n = 0; ifc.mem_rdata = 64'h00000000000055AA; ifc.mem_ready = 1;
    tick();
    n_vec++; if ({ifc.valid, ifc.busy, ifc.err_align, ifc.err_timeout} !== 4'b0000) begin n_err++; $display("FAIL rstwait_flags got %b want 0000", {ifc.valid, ifc.busy, ifc.err_align, ifc.err_timeout}); end
    n_vec++; if (ifc.d_out !== 64'h0) begin n_err++; $display("FAIL rstwait_d_out got %h want 0", ifc.d_out); end
    rst_n = 1; ifc.mem_ready = 0;
    tick();
    n_vec++; if ({ifc.valid, ifc.busy} !== 2'b00) begin n_err++; $display("FAIL rstwait_after got %b want 00", {ifc.valid, ifc.busy}); end
  endtask

  initial begin
    init_inputs();
    test_reset();
    test_byte_sext();
    test_back_to_back();
    test_misalign();
    test_lmd_in_wait();
    test_timeout();
    test_big_endian();
    test_dword64();
    test_reset_mid_wait();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
